// File: rtl/serdes_tx_pkg.sv
// Shared definitions for the 8:1 serializer: FSM states, default line words
// and the user-word counter width used by both ends of the link.
package serdes_tx_pkg;

  typedef enum logic {
    TRAIN = 1'b0,
    DATA  = 1'b1
  } tx_state_t;

  localparam logic [7:0] TRAIN_WORD_DEF = 8'h55;
  localparam logic [7:0] IDLE_WORD_DEF  = 8'h01;
  localparam int         WORDS_CNT_W    = 16;

endpackage

// File: rtl/serdes_tx_shift.sv
// Load/shift register for the serializer: presents the MSB on the line,
// shifts left each cycle and reloads a whole word on the last bit.
module serdes_tx_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_word,
  output logic             serial,
  output logic             boundary,
  output logic             word_start
);

  localparam int                CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] bit_cnt;

  // Reset parks the counter on the last bit so the first edge after release loads a word.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '1;
      bit_cnt <= LAST;
    end else if (boundary) begin
      shift_q <= load_word;
      bit_cnt <= '0;
    end else begin
      shift_q <= {shift_q[WIDTH-2:0], 1'b0};
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  assign serial     = shift_q[WIDTH-1];
  assign boundary   = (bit_cnt == LAST);
  assign word_start = (bit_cnt == '0) && !rst;

endmodule

// File: rtl/serdes_tx_8_1.sv
// 8:1 word serializer: training burst after reset or retrain request, then
// user words MSB-first with IDLE_WORD filler whenever no word is offered.
module serdes_tx_8_1
  import serdes_tx_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               TRAIN_COUNT = 10,
  parameter logic [WIDTH-1:0] TRAIN_WORD  = WIDTH'(TRAIN_WORD_DEF),
  parameter logic [WIDTH-1:0] IDLE_WORD   = WIDTH'(IDLE_WORD_DEF)
) (
  input  logic                   clk_serdes_i,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   data_valid_i,
  output logic                   data_ready_o,
  input  logic                   retrain_i,
  output logic                   tx_data_o,
  output logic                   word_start_o,
  output logic                   training_o,
  output logic [WORDS_CNT_W-1:0] words_sent_o
);

  localparam int              WC_W    = (TRAIN_COUNT > 2) ? $clog2(TRAIN_COUNT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TRAIN_COUNT - 1);

  tx_state_t              state_q, state_d;
  logic [WC_W-1:0]        word_cnt_q, word_cnt_d;
  logic                   retrain_pend_q, retrain_pend_d;
  logic [WORDS_CNT_W-1:0] words_sent_q;
  logic [WIDTH-1:0]       next_word;
  logic                   boundary;
  logic                   accept;

  serdes_tx_shift #(.WIDTH(WIDTH)) u_shift (
    .clk        (clk_serdes_i),
    .rst        (rst),
    .load_word  (next_word),
    .serial     (tx_data_o),
    .boundary   (boundary),
    .word_start (word_start_o)
  );

  assign data_ready_o = (state_q == DATA) && boundary && !retrain_pend_q && !rst;
  assign accept       = data_ready_o && data_valid_i;

  // Word selection at each boundary; a retrain request arriving on the boundary
  // itself only takes effect at the following boundary.
  always_comb begin
    next_word      = IDLE_WORD;
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    retrain_pend_d = retrain_pend_q;
    if (boundary) begin
      case (state_q)
        TRAIN: begin
          next_word = TRAIN_WORD;
          if (word_cnt_q == WC_LAST) begin
            word_cnt_d = '0;
            state_d    = DATA;
          end else begin
            word_cnt_d = word_cnt_q + WC_W'(1);
          end
        end
        DATA: begin
          if (retrain_pend_q) begin
            next_word      = TRAIN_WORD;
            retrain_pend_d = 1'b0;
            if (TRAIN_COUNT == 1) begin
              word_cnt_d = '0;
            end else begin
              word_cnt_d = WC_W'(1);
              state_d    = TRAIN;
            end
          end else if (data_valid_i) begin
            next_word = data_i;
          end
        end
        default: next_word = IDLE_WORD;
      endcase
    end
    if (retrain_i && (state_q == DATA) && !(boundary && retrain_pend_q)) begin
      retrain_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_serdes_i) begin
    if (rst) begin
      state_q        <= TRAIN;
      word_cnt_q     <= '0;
      retrain_pend_q <= 1'b0;
      words_sent_q   <= '0;
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      retrain_pend_q <= retrain_pend_d;
      if (accept) words_sent_q <= words_sent_q + WORDS_CNT_W'(1);
    end
  end

  assign training_o   = (state_q == TRAIN) || retrain_pend_q;
  assign words_sent_o = words_sent_q;

endmodule

// File: tb/tb_serdes_tx_8_1.sv
// Randomized self-checking bench for serdes_tx_8_1 against a word-level model
// of the link (training count, pending retrain, expected serial bit queue).
module tb_serdes_tx_8_1;

  localparam int         W  = 8;
  localparam int         TC = 10;
  localparam logic [7:0] TW = 8'h55;
  localparam logic [7:0] IW = 8'h01;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        data_valid;
  logic        data_ready;
  logic        retrain;
  logic        tx_data;
  logic        word_start;
  logic        training;
  logic [15:0] words_sent;

  always #5 clk = ~clk;

  serdes_tx_8_1 dut (
    .clk_serdes_i (clk),
    .rst          (rst),
    .data_i       (data),
    .data_valid_i (data_valid),
    .data_ready_o (data_ready),
    .retrain_i    (retrain),
    .tx_data_o    (tx_data),
    .word_start_o (word_start),
    .training_o   (training),
    .words_sent_o (words_sent)
  );

  int errors = 0;
  int checks = 0;

  // Word-level reference: edges since release, training words still owed,
  // pending retrain, accepted count and the queue of bits still to appear.
  int          edge_cnt;
  int          train_left;
  bit          req;
  logic [15:0] sent;
  bit          q[$];

  logic        exp_ready, exp_tx, exp_ws, exp_tr;
  logic        act_ready, act_tx, act_ws, act_tr;
  logic [15:0] act_sent;

  task automatic cycle(input logic v, input logic [7:0] d, input logic rt);
    logic       bnd, was_data;
    logic [7:0] w;
    @(negedge clk);
    data_valid = v; data = d; retrain = rt;
    #1;
    bnd       = (edge_cnt % W) == 0;
    exp_ready = !rst && bnd && train_left == 0 && !req;
    act_ready = data_ready;
    @(posedge clk);
    if (rst) begin
      edge_cnt = 0; train_left = TC; req = 0; sent = 0; q.delete();
      exp_tx = 1'b1; exp_ws = 1'b0;
    end else begin
      was_data = (train_left == 0) && !(bnd && req);
      if (bnd) begin
        if (train_left > 0) begin w = TW; train_left--; end
        else if (req) begin w = TW; train_left = TC - 1; req = 0; end
        else if (v) begin w = d; sent++; end
        else w = IW;
        for (int i = W - 1; i >= 0; i--) q.push_back(w[i]);
      end
      if (rt && was_data) req = 1;
      exp_ws = (edge_cnt % W) == 0;
      exp_tx = (q.size() > 0) ? q.pop_front() : 1'b1;
      edge_cnt++;
    end
    exp_tr = (train_left > 0) || req;
    #1;
    act_tx = tx_data; act_ws = word_start; act_tr = training; act_sent = words_sent;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'hA3, 1'b1);
      if (act_tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx got=%b exp=1", act_tx); end
      checks++;
      if (act_ws !== 1'b0 || act_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL reset_ws_ready got=%b/%b exp=0/0", act_ws, act_ready);
      end
      checks++;
      if (act_tr !== 1'b1 || act_sent !== 16'd0) begin
        errors++; $display("[TB] FAIL reset_tr_sent got=%b/%0d exp=1/0", act_tr, act_sent);
      end
      checks++;
    end
    rst = 1'b0;
  endtask

  task automatic test_training_idle;
    int first_ready = -1;
    for (int i = 0; i < 120; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      if (act_ready && first_ready < 0) first_ready = i;
      if (act_tx !== exp_tx) begin errors++; $display("[TB] FAIL train_tx e=%0d got=%b exp=%b", i, act_tx, exp_tx); end
      checks++;
      if (act_ws !== exp_ws) begin errors++; $display("[TB] FAIL train_ws e=%0d got=%b exp=%b", i, act_ws, exp_ws); end
      checks++;
      if (act_tr !== exp_tr) begin errors++; $display("[TB] FAIL train_tr e=%0d got=%b exp=%b", i, act_tr, exp_tr); end
      checks++;
      if (act_ready !== exp_ready) begin errors++; $display("[TB] FAIL train_ready e=%0d got=%b exp=%b", i, act_ready, exp_ready); end
      checks++;
    end
    if (first_ready !== TC * W) begin
      errors++; $display("[TB] FAIL first_ready got=%0d exp=%0d", first_ready, TC * W);
    end
    checks++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] words[3] = '{8'hA3, 8'h3C, 8'hFF};
    int         idx = 0;
    logic [15:0] base = sent;
    int         guard = 0;
    while (idx < 3 && guard < 60) begin
      cycle(1'b1, words[idx], 1'b0);
      guard++;
      if (act_tx !== exp_tx || act_ready !== exp_ready) begin
        errors++; $display("[TB] FAIL b2b_line tx/ready got=%b/%b exp=%b/%b", act_tx, act_ready, exp_tx, exp_ready);
      end
      checks++;
      if (act_ready) idx++;
    end
    if (idx != 3) begin errors++; $display("[TB] FAIL b2b_accepts got=%0d exp=3", idx); end
    checks++;
    for (int i = 0; i < 3 * W; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      if (act_tx !== exp_tx) begin errors++; $display("[TB] FAIL b2b_tx got=%b exp=%b", act_tx, exp_tx); end
      checks++;
      if (act_sent !== sent) begin errors++; $display("[TB] FAIL b2b_sent got=%0d exp=%0d", act_sent, sent); end
      checks++;
    end
    if (act_sent !== base + 16'd3) begin
      errors++; $display("[TB] FAIL b2b_count got=%0d exp=%0d", act_sent, base + 16'd3);
    end
    checks++;
  endtask

  task automatic test_mid_word_valid;
    int         guard = 0;
    int         waited = 0;
    int         pulses = 0;
    int         exp_wait;
    logic [7:0] d = 8'($urandom);
    while ((edge_cnt % W) != 3 && guard < 2 * W) begin cycle(1'b0, 8'h00, 1'b0); guard++; end
    exp_wait = W - (edge_cnt % W) + 1;
    while (pulses == 0 && waited < 3 * W) begin
      cycle(1'b1, d, 1'b0);
      waited++;
      if (act_ready) pulses++;
      if (act_ready !== exp_ready || act_tx !== exp_tx) begin
        errors++; $display("[TB] FAIL mid_ready_tx got=%b/%b exp=%b/%b", act_ready, act_tx, exp_ready, exp_tx);
      end
      checks++;
    end
    if (waited != exp_wait) begin errors++; $display("[TB] FAIL mid_wait got=%0d exp=%0d", waited, exp_wait); end
    checks++;
    cycle(1'b1, d, 1'b0);
    if (act_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_pulse_width got=%b exp=0", act_ready); end
    checks++;
    for (int i = 0; i < 2 * W; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      if (act_tx !== exp_tx) begin errors++; $display("[TB] FAIL mid_tx got=%b exp=%b", act_tx, exp_tx); end
      checks++;
    end
  endtask

  task automatic test_retrain;
    int  first_ready = -1;
    bit  saw_train = 0;
    while ((edge_cnt % W) != 4) cycle(1'b1, 8'($urandom), 1'b0);
    cycle(1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < 110; i++) begin
      cycle($urandom_range(0, 1) == 1, 8'($urandom), 1'b0);
      if (act_tr) saw_train = 1;
      if (act_tx !== exp_tx || act_tr !== exp_tr) begin
        errors++; $display("[TB] FAIL retrain_data tx/tr got=%b/%b exp=%b/%b", act_tx, act_tr, exp_tx, exp_tr);
      end
      checks++;
      if (act_ready !== exp_ready || act_sent !== sent) begin
        errors++; $display("[TB] FAIL retrain_ready_sent got=%b/%0d exp=%b/%0d", act_ready, act_sent, exp_ready, sent);
      end
      checks++;
    end
    if (!saw_train) begin errors++; $display("[TB] FAIL retrain_seen got=0 exp=1"); end
    checks++;
    apply_reset(2);
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 8'h00, i == 20 || i == 45);
      if (act_ready && first_ready < 0) first_ready = i;
      if (act_tx !== exp_tx || act_tr !== exp_tr) begin
        errors++; $display("[TB] FAIL retrain_in_train tx/tr got=%b/%b exp=%b/%b", act_tx, act_tr, exp_tx, exp_tr);
      end
      checks++;
    end
    if (first_ready !== TC * W) begin
      errors++; $display("[TB] FAIL retrain_in_train_ready got=%0d exp=%0d", first_ready, TC * W);
    end
    checks++;
  endtask

  task automatic test_reset_mid_word;
    int guard = 0;
    while (!act_ready && guard < 3 * W) begin cycle(1'b1, 8'hA3, 1'b0); guard++; end
    if (!act_ready) begin errors++; $display("[TB] FAIL rmw_accept got=0 exp=1"); end
    checks++;
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    if (act_tx !== 1'b1 || act_ws !== 1'b0 || act_tr !== 1'b1 || act_sent !== 16'd0) begin
      errors++; $display("[TB] FAIL rmw_reset tx/ws/tr/sent got=%b/%b/%b/%0d exp=1/0/1/0", act_tx, act_ws, act_tr, act_sent);
    end
    checks++;
    rst = 1'b0;
    for (int i = 0; i < TC * W + 2; i++) begin
      cycle(1'b0, 8'h00, 1'b0);
      if (act_tx !== exp_tx || act_ws !== exp_ws || act_tr !== exp_tr) begin
        errors++; $display("[TB] FAIL rmw_burst e=%0d tx/ws/tr got=%b/%b/%b exp=%b/%b/%b", i, act_tx, act_ws, act_tr, exp_tx, exp_ws, exp_tr);
      end
      checks++;
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 79) == 0);
      if (act_tx !== exp_tx || act_ws !== exp_ws) begin
        errors++; $display("[TB] FAIL rand_line tx/ws got=%b/%b exp=%b/%b", act_tx, act_ws, exp_tx, exp_ws);
      end
      checks++;
      if (act_ready !== exp_ready || act_tr !== exp_tr || act_sent !== sent) begin
        errors++; $display("[TB] FAIL rand_ctrl ready/tr/sent got=%b/%b/%0d exp=%b/%b/%0d", act_ready, act_tr, act_sent, exp_ready, exp_tr, sent);
      end
      checks++;
    end
  endtask

  // Receive side: deserialize from an arbitrary bit offset, bitslip until the
  // idle marker lines up, then recover the user stream at that alignment.
  task automatic test_loopback;
    bit         rx[$];
    logic [7:0] words[2] = '{8'hA3, 8'h3C};
    logic [7:0] w, prev;
    int         lock = -1;
    int         idx = 0;
    int         guard = 0;
    bit         found = 0;
    while ((training || (edge_cnt % W) != 3) && guard < 200) begin cycle(1'b0, 8'h00, 1'b0); guard++; end
    for (int i = 0; i < 3 * W; i++) begin cycle(1'b0, 8'h00, 1'b0); rx.push_back(act_tx); end
    for (int s = 0; s < W && lock < 0; s++) begin
      for (int b = 0; b < W; b++) w[W - 1 - b] = rx[s + b];
      if (w == IW) lock = s;
    end
    if (lock < 0) begin errors++; $display("[TB] FAIL loop_lock got=none exp=slip"); end
    checks++;
    guard = 0;
    while (idx < 2 && guard < 40) begin
      cycle(1'b1, words[idx], 1'b0);
      rx.push_back(act_tx);
      if (act_ready) idx++;
      guard++;
    end
    for (int i = 0; i < 3 * W; i++) begin cycle(1'b0, 8'h00, 1'b0); rx.push_back(act_tx); end
    prev = 8'h00;
    if (lock >= 0) begin
      for (int k = lock; k + W <= rx.size(); k += W) begin
        for (int b = 0; b < W; b++) w[W - 1 - b] = rx[k + b];
        if (prev == 8'hA3 && w == 8'h3C) found = 1;
        prev = w;
      end
    end
    if (!found) begin errors++; $display("[TB] FAIL loop_recover got=absent exp=A3,3C"); end
    checks++;
  endtask

  initial begin
    rst = 1'b1; data = 8'h00; data_valid = 1'b0; retrain = 1'b0;
    edge_cnt = 0; train_left = TC; req = 0; sent = 0;
    $display("[TB] serdes_tx_8_1 bench start");
    test_reset;
    test_training_idle;
    test_back_to_back;
    test_mid_word_valid;
    test_retrain;
    test_reset_mid_word;
    test_random;
    test_loopback;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
